// File: rtl/ifid_skid_stage_if.sv
// IF->ID handshake bundle: fetch-side inputs, decode-side outputs and flush.
// The stage uses the slave modport; the environment drives the master side.
interface ifid_skid_stage_if #(
   parameter int DATA_WIDTH = 32
) ();
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] instr;
   logic [DATA_WIDTH-1:0] PCF;
   logic [DATA_WIDTH-1:0] PCPlus4F;
   logic                  FlushD;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] instrD;
   logic [DATA_WIDTH-1:0] PCD;
   logic [DATA_WIDTH-1:0] PCPlus4D;

   modport master (
      output in_valid, instr, PCF, PCPlus4F,
      output FlushD, out_ready,
      input  in_ready, out_valid,
      input  instrD, PCD, PCPlus4D
   );

   modport slave (
      input  in_valid, instr, PCF, PCPlus4F,
      input  FlushD, out_ready,
      output in_ready, out_valid,
      output instrD, PCD, PCPlus4D
   );
endinterface

// File: rtl/ifid_skid_stage.sv
// IF->ID valid/ready stage with a 2-entry skid buffer and registered in_ready.
// Optional perf counters (stall_cnt, flush_cnt) under IFID_PERF_CNT_EN.
module ifid_skid_stage #(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(32'h00000013)
`ifdef IFID_PERF_CNT_EN
 , parameter int                    CNT_WIDTH  = 16
`endif
) (
   input  logic                 clk,
   input  logic                 rst_n,
   ifid_skid_stage_if.slave     bus
`ifdef IFID_PERF_CNT_EN
 , output logic [CNT_WIDTH-1:0] stall_cnt,
   output logic [CNT_WIDTH-1:0] flush_cnt
`endif
);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] instr;
      logic [DATA_WIDTH-1:0] pc;
      logic [DATA_WIDTH-1:0] pc4;
   } entry_t;

   localparam logic [1:0] S_EMPTY = 2'd0;
   localparam logic [1:0] S_ONE   = 2'd1;
   localparam logic [1:0] S_FULL  = 2'd2;

   localparam entry_t BUBBLE = '{
      instr: NOP_INSTR,
      pc:    '0,
      pc4:   '0
   };

   logic [1:0] state_q, state_d;
   entry_t     main_q, main_d;
   entry_t     skid_q, skid_d;
   entry_t     in_ent;
   logic       in_ready_q;
   logic       out_valid_q;
   logic       in_fire;
   logic       out_fire;

   assign in_ent   = '{
      instr: bus.instr,
      pc:    bus.PCF,
      pc4:   bus.PCPlus4F
   };
   assign in_fire  = bus.in_valid & in_ready_q;
   assign out_fire = out_valid_q & bus.out_ready;

   // main is reloaded with BUBBLE whenever it empties, so outputs stay flop-driven
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (bus.FlushD) begin
         state_d = S_EMPTY;
         main_d  = BUBBLE;
      end else begin
         unique case (state_q)
            S_EMPTY: begin
               if (in_fire) begin
                  state_d = S_ONE;
                  main_d  = in_ent;
               end
            end
            S_ONE: begin
               if (in_fire && out_fire) begin
                  main_d = in_ent;
               end else if (in_fire) begin
                  state_d = S_FULL;
                  skid_d  = in_ent;
               end else if (out_fire) begin
                  state_d = S_EMPTY;
                  main_d  = BUBBLE;
               end
            end
            S_FULL: begin
               if (out_fire) begin
                  state_d = S_ONE;
                  main_d  = skid_q;
               end
            end
            default: begin
               state_d = S_EMPTY;
               main_d  = BUBBLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_EMPTY;
         main_q      <= BUBBLE;
         skid_q      <= BUBBLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         in_ready_q  <= (state_d != S_FULL);
         out_valid_q <= (state_d != S_EMPTY);
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.instrD    = main_q.instr;
   assign bus.PCD       = main_q.pc;
   assign bus.PCPlus4D  = main_q.pc4;

`ifdef IFID_PERF_CNT_EN
   logic [CNT_WIDTH-1:0] stall_q;
   logic [CNT_WIDTH-1:0] flush_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (out_valid_q && !bus.out_ready && !(&stall_q))
            stall_q <= stall_q + CNT_WIDTH'(1);
         if (bus.FlushD && !(&flush_q))
            flush_q <= flush_q + CNT_WIDTH'(1);
      end
   end

   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;
`endif

endmodule
